manch_encoder: RTL and testbench
================================

# manch_encoder

Manchester line encoder feeding the Manchester decoder stage: it accepts bytes over a valid/ready handshake and serialises each one as a Manchester-coded frame on a single line. The frame is a fixed preamble followed by 8 data bits, LSB first, then a guaranteed idle gap. Half-bit timing uses the same `BAUDRATE`/`CLK_FREQ` convention as the decoder, so its edge-window check accepts every transition.

## Interface
- `BAUDRATE`, 115200 * 2, half-bit rate in Hz (twice the data bit rate)
- `CLK_FREQ`, 18_750_000, clock frequency in Hz
- `PRE_BITS`, 2, number of preamble bits (each is a logical 1), range 1–15
- `GAP_HALFBITS`, 3, idle half-bits after each frame; minimum 3
- `clk`  input  1  system clock; one clock domain
- `rst_n`  input  1  reset, asynchronous assert, active-low
- `in_data`  input  8  byte to transmit
- `in_valid`  input  1  `in_data` is valid
- `in_ready`  output  1  encoder can accept a byte
- `manch_out`  output  1  Manchester line output, registered
- `busy`  output  1  a frame or its gap is in progress

## Operation
- Half-bit period: `HALFBIT = CLK_FREQ / BAUDRATE`, integer division. With the defaults this is 81 cycles.
- Encoding:
  - Logical 1 is low for the first half-bit, then high for the second (rising edge at mid-bit).
  - Logical 0 is high for the first half-bit, then low for the second.
- Idle line level is 0.
- FSM states:
  - IDLE: `in_ready` = 1. A transfer when `in_valid && in_ready` latches `in_data` into the shift register and moves to PRE.
  - PRE: sends `PRE_BITS` ones, then moves to DATA.
  - DATA: sends shift register bits 0 through 7, then moves to GAP.
  - GAP: `manch_out` = 0 for `GAP_HALFBITS` × `HALFBIT` cycles, then returns to IDLE.
- Output decodes:
  - `in_ready` = 1 only in IDLE. It is a combinational decode of the state register.
  - `busy` = 1 in PRE, DATA and GAP.
- `in_valid` is ignored outside IDLE. `in_data` is sampled only on the accept cycle.
- Reset values: state IDLE, `manch_out` 0, `busy` 0, `in_ready` 1, all counters 0.
- Reset asserted mid-frame:
  - `manch_out` drops to 0 immediately (asynchronously).
  - The frame is abandoned, with no resume after reset.
- Counter widths:
  - Half-bit counter: `$clog2(HALFBIT)` bits. It counts 0..`HALFBIT`-1 and wraps to 0, producing a half-bit tick.
  - Bit counter: 4 bits.
  - Gap counter: `$clog2(GAP_HALFBITS+1)` bits.

## Timing
- Accept at posedge t, i.e. the cycle where `in_valid && in_ready` = 1.
- At t+1:
  - `manch_out` drives the first half of preamble bit 0.
  - `busy` rises and `in_ready` falls.
- Each half-bit lasts exactly `HALFBIT` cycles. Active frame length is `(PRE_BITS+8)*2*HALFBIT`, which is 1620 cycles with the defaults.
- Every transition is spaced either `HALFBIT` or 2×`HALFBIT` cycles from the previous one.
- Transition at the frame end:
  - If the last data bit is 1, `manch_out` falls to idle when the gap starts.
  - If the last data bit is 0, there is no transition.
- The gap lasts `GAP_HALFBITS`×`HALFBIT` cycles (243 with the defaults). This exceeds 2×`HALFBIT`, so the decoder's counter resets between frames.
- `in_ready` returns at t+1+1620+243 = t+1864 with the defaults.
- Back-to-back operation: a byte with `in_valid` held high is accepted on the first cycle `in_ready` is high. Throughput is one frame every 1864 cycles.
- Accept-to-first-edge latency: 1 cycle. There is no other pipelining.

## Structure
- Shared package `manch_pkg` contains:
  - the `manch_state_t` enum (IDLE, PRE, DATA, GAP);
  - the `halfbit_cycles(clk_freq, baudrate)` function;
  - the constant `MANCH_IDLE_LEVEL = 1'b0`.
- `halfbit_cycles` is reused by the decoder.
- Sub-module `manch_halfbit_timer`:
  - Inputs: `clk`, `rst_n`, `restart`, `enable`.
  - Output: `tick`, a one-cycle pulse every `HALFBIT` cycles.
  - It is restarted on accept.
- The top level holds the FSM, shift register, bit and gap counters, and the output register.

## Test plan
- Reset, then 0xA5 with default parameters:
  - `manch_out` shows the preamble 1,1 then bits 1,0,1,0,0,1,0,1.
  - Each half-bit lasts 81 cycles.
  - The first edge is at t+1, and `in_ready` returns at t+1864.
- `in_valid` held high with 0x00 then 0xFF:
  - The second byte is accepted exactly at t+1864.
  - 0x00 produces mid-bit falling edges; 0xFF produces mid-bit rising edges.
- `in_valid` pulsed with 0x3C during DATA: the pulse is ignored, and the frame in flight and `in_ready` are unchanged.
- `rst_n` asserted at the 700th cycle of a frame:
  - `manch_out` is 0 and `busy` is 0 in the same cycle.
  - After release, `in_ready` is 1 and a new byte 0x5A transmits cleanly.
- Loopback of `manch_out` into the decoder with bytes 0x01, 0x80, 0xC3: the decoder output matches each encoded bit after every mid-bit edge.
- `PRE_BITS`=1 and `GAP_HALFBITS`=3 with byte 0x00: the frame is 9×162 cycles, and `in_ready` returns at t+1+1458+243.

Source files
------------

// File: rtl/manch_pkg.sv
// Shared Manchester line definitions used by both the encoder and the decoder stage.
// Holds the frame FSM states, the idle line level and the half-bit period helper.
package manch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PRE  = 2'd1,
    DATA = 2'd2,
    GAP  = 2'd3
  } manch_state_t;

  localparam logic MANCH_IDLE_LEVEL = 1'b0;

  // Clock cycles per half-bit; integer division so both ends agree on the period.
  function automatic int halfbit_cycles(input int clk_freq, input int baudrate);
    return clk_freq / baudrate;
  endfunction

endpackage

// File: rtl/manch_encoder_halfbit_timer.sv
// Free-running half-bit divider: emits a one-cycle tick every HALFBIT enabled cycles.
// A restart zeroes the count so the first half-bit after an accept is full length.
module manch_halfbit_timer #(
  parameter int HALFBIT = 81
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  input  logic enable,
  output logic tick
);

  localparam int CW = (HALFBIT > 1) ? $clog2(HALFBIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(HALFBIT - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    tick  = 1'b0;
    if (restart) begin
      cnt_d = '0;
    end else if (enable) begin
      if (cnt_q == LAST) begin
        cnt_d = '0;
        tick  = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/manch_encoder.sv
// Manchester line encoder: accepts a byte over valid/ready and sends preamble ones,
// eight data bits LSB first, then a fixed idle gap on a registered output.
module manch_encoder
  import manch_pkg::*;
#(
  parameter int BAUDRATE     = 115200 * 2,
  parameter int CLK_FREQ     = 18_750_000,
  parameter int PRE_BITS     = 2,
  parameter int GAP_HALFBITS = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       manch_out,
  output logic       busy
);

  localparam int HALFBIT = halfbit_cycles(CLK_FREQ, BAUDRATE);
  localparam int GW      = $clog2(GAP_HALFBITS + 1);
  localparam logic [3:0]    PRE_LAST = 4'(PRE_BITS - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_HALFBITS - 1);

  manch_state_t  state_q, state_d;
  logic [7:0]    shreg_q, shreg_d;
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic [GW-1:0] gap_cnt_q, gap_cnt_d;
  logic          half_q, half_d;
  logic          manch_q, manch_d;
  logic          accept;
  logic          tick;

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign accept    = in_valid && in_ready;
  assign manch_out = manch_q;

  manch_halfbit_timer #(
    .HALFBIT(HALFBIT)
  ) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .restart(accept),
    .enable (busy),
    .tick   (tick)
  );

  // manch_q always holds the level of the current half-bit; each tick loads the next one.
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    gap_cnt_d = gap_cnt_q;
    half_d    = half_q;
    manch_d   = manch_q;
    case (state_q)
      IDLE: begin
        manch_d = MANCH_IDLE_LEVEL;
        if (accept) begin
          state_d   = PRE;
          shreg_d   = in_data;
          bit_cnt_d = 4'd0;
          half_d    = 1'b0;
          manch_d   = 1'b0;
        end
      end
      PRE: begin
        if (tick) begin
          if (!half_q) begin
            half_d  = 1'b1;
            manch_d = 1'b1;
          end else begin
            half_d = 1'b0;
            if (bit_cnt_q == PRE_LAST) begin
              state_d   = DATA;
              bit_cnt_d = 4'd0;
              manch_d   = ~shreg_q[0];
            end else begin
              bit_cnt_d = bit_cnt_q + 4'd1;
              manch_d   = 1'b0;
            end
          end
        end
      end
      DATA: begin
        if (tick) begin
          if (!half_q) begin
            half_d  = 1'b1;
            manch_d = shreg_q[0];
          end else begin
            half_d  = 1'b0;
            shreg_d = shreg_q >> 1;
            if (bit_cnt_q == 4'd7) begin
              state_d   = GAP;
              gap_cnt_d = '0;
              manch_d   = MANCH_IDLE_LEVEL;
            end else begin
              bit_cnt_d = bit_cnt_q + 4'd1;
              manch_d   = ~shreg_q[1];
            end
          end
        end
      end
      GAP: begin
        manch_d = MANCH_IDLE_LEVEL;
        if (tick) begin
          if (gap_cnt_q == GAP_LAST) begin
            state_d   = IDLE;
            gap_cnt_d = '0;
          end else begin
            gap_cnt_d = gap_cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        manch_d = MANCH_IDLE_LEVEL;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      gap_cnt_q <= '0;
      half_q    <= 1'b0;
      manch_q   <= MANCH_IDLE_LEVEL;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      half_q    <= half_d;
      manch_q   <= manch_d;
    end
  end

endmodule

// File: tb/tb_manch_encoder.sv
// Directed bench for manch_encoder: checks every cycle of each frame against a
// hand-built waveform model, plus reset, back-to-back, ignored-valid and PRE_BITS=1 cases.
module tb_manch_encoder;

  localparam int HB = 81;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] in_data;
  logic       in_valid0, in_valid1;
  logic       in_ready0, manch_out0, busy0;
  logic       in_ready1, manch_out1, busy1;
  int         total = 0;
  int         bad   = 0;

  always #5 clk = ~clk;

  manch_encoder #(
    .BAUDRATE    (115200 * 2),
    .CLK_FREQ    (18_750_000),
    .PRE_BITS    (2),
    .GAP_HALFBITS(3)
  ) u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_data  (in_data),
    .in_valid (in_valid0),
    .in_ready (in_ready0),
    .manch_out(manch_out0),
    .busy     (busy0)
  );

  manch_encoder #(
    .BAUDRATE    (115200 * 2),
    .CLK_FREQ    (18_750_000),
    .PRE_BITS    (1),
    .GAP_HALFBITS(3)
  ) u_dut_pre1 (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_data  (in_data),
    .in_valid (in_valid1),
    .in_ready (in_ready1),
    .manch_out(manch_out1),
    .busy     (busy1)
  );

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Expected line level in cycle k after the accept (k=1 is the first frame cycle).
  function automatic logic exp_level(input int k, input logic [7:0] d, input int pre);
    int   hi;
    int   bi;
    logic v;
    hi = (k - 1) / HB;
    bi = hi / 2;
    if (bi >= pre + 8) return 1'b0;
    v = (bi < pre) ? 1'b1 : d[bi - pre];
    return (hi % 2 == 1) ? v : ~v;
  endfunction

  task automatic run_frame(input bit sel, input logic [7:0] d, input bit hold,
                           input int pulse_at, input int rst_at, input string tag);
    int         pre, len, waited, hi;
    int         mo_err, rdy_err, busy_err;
    logic       mo, rdy, bz;
    logic [7:0] dec;
    pre      = sel ? 1 : 2;
    len      = (pre + 8) * 2 * HB + 3 * HB;
    mo_err   = 0;
    rdy_err  = 0;
    busy_err = 0;
    dec      = 8'h00;
    in_data  = d;
    if (sel) in_valid1 = 1'b1;
    else     in_valid0 = 1'b1;
    waited = 0;
    rdy    = sel ? in_ready1 : in_ready0;
    while (!rdy && waited < 4000) begin
      @(negedge clk);
      waited++;
      rdy = sel ? in_ready1 : in_ready0;
    end
    chk({tag, "_wait"}, waited, 0);
    if (waited >= 4000) return;
    for (int k = 1; k <= len + 1; k++) begin
      @(negedge clk);
      mo  = sel ? manch_out1 : manch_out0;
      rdy = sel ? in_ready1  : in_ready0;
      bz  = sel ? busy1      : busy0;
      if (k == 1 && !hold) begin
        in_valid0 = 1'b0;
        in_valid1 = 1'b0;
      end
      if (pulse_at != 0 && k == pulse_at) begin
        in_valid0 = 1'b1;
        in_data   = 8'h3C;
      end
      if (pulse_at != 0 && k == pulse_at + 1) begin
        in_valid0 = 1'b0;
        in_data   = d;
      end
      if (k == rst_at) begin
        rst_n = 1'b0;
        #1;
        chk({tag, "_rst_mo"},   int'(sel ? manch_out1 : manch_out0), 0);
        chk({tag, "_rst_busy"}, int'(sel ? busy1 : busy0), 0);
        chk({tag, "_rst_rdy"},  int'(sel ? in_ready1 : in_ready0), 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk({tag, "_post_rdy"}, int'(sel ? in_ready1 : in_ready0), 1);
        $display("frame %s data=%02h aborted by reset at cycle %0d", tag, d, k);
        return;
      end
      if (k <= len) begin
        if (mo !== exp_level(k, d, pre)) mo_err++;
        if (rdy !== 1'b0) rdy_err++;
        if (bz !== 1'b1) busy_err++;
        hi = (k - 1) / HB;
        if ((hi % 2 == 1) && ((k - 1) % HB == HB / 2) && (hi / 2 >= pre) && (hi / 2 < pre + 8))
          dec[hi / 2 - pre] = mo;
      end else begin
        chk({tag, "_rdy_return"},  int'(rdy), 1);
        chk({tag, "_busy_return"}, int'(bz), 0);
        chk({tag, "_idle_level"},  int'(mo), 0);
      end
    end
    chk({tag, "_wave_err"}, mo_err, 0);
    chk({tag, "_rdy_err"},  rdy_err, 0);
    chk({tag, "_busy_err"}, busy_err, 0);
    chk({tag, "_decoded"},  int'(dec), int'(d));
    $display("frame %s data=%02h decoded=%02h len=%0d", tag, d, dec, len);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid0 = 1'b0;
    in_valid1 = 1'b0;
    in_data   = 8'h00;
    repeat (3) @(negedge clk);
    chk("reset_mo",   int'(manch_out0), 0);
    chk("reset_busy", int'(busy0), 0);
    chk("reset_rdy",  int'(in_ready0), 1);
    chk("reset_rdy1", int'(in_ready1), 1);
    rst_n = 1'b1;
    @(negedge clk);

    run_frame(1'b0, 8'hA5, 1'b0, 0, 0, "a5");
    repeat (5) @(negedge clk);
    run_frame(1'b0, 8'h00, 1'b1, 0, 0, "b2b_00");
    run_frame(1'b0, 8'hFF, 1'b0, 0, 0, "b2b_ff");
    repeat (4) @(negedge clk);
    run_frame(1'b0, 8'h96, 1'b0, 500, 0, "pulse");
    run_frame(1'b0, 8'hC3, 1'b0, 0, 700, "rst");
    run_frame(1'b0, 8'h5A, 1'b0, 0, 0, "after_rst");
    run_frame(1'b0, 8'h01, 1'b0, 0, 0, "loop_01");
    run_frame(1'b0, 8'h80, 1'b0, 0, 0, "loop_80");
    run_frame(1'b0, 8'hC3, 1'b0, 0, 0, "loop_c3");
    run_frame(1'b1, 8'h00, 1'b0, 0, 0, "pre1_00");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
